// File: rtl/os_lane_checker.sv
// os_lane_checker
// Checks each lane's received ordered set against the match rule of the
// current LTSSM substate and keeps a per-lane saturating count of
// consecutive matching sets. It also captures the rate identifier and the
// upconfigure bit from the first set of each run. From those counts it
// reports per-lane and link-wide "required count reached".
module os_lane_checker #(
    parameter int LANES      = 4,
    parameter int DEVICETYPE = 0,
    parameter int CNT_W      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             substate,
    input  logic [7:0]             linkNumber,
    input  logic [LANES*8-1:0]     laneNumber,
    input  logic [LANES*128-1:0]   orderedset,
    input  logic [LANES-1:0]       valid,
    input  logic [LANES-1:0]       lane_mask,
    input  logic [CNT_W-1:0]       required_count,
    output logic [LANES*CNT_W-1:0] lane_count,
    output logic [LANES-1:0]       lane_done,
    output logic                   all_done,
    output logic [LANES*8-1:0]     rateid,
    output logic [LANES-1:0]       upconfigure_capability
);

    localparam logic [7:0]       PAD     = 8'hF7;
    localparam logic [7:0]       TS1     = 8'h2A;
    localparam logic [7:0]       TS2     = 8'h45;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Decides whether one lane's set satisfies the rule of the given substate.
    function automatic logic setMatches(
        input logic [3:0] st,
        input logic [7:0] linkField,
        input logic [7:0] laneField,
        input logic [7:0] tsField,
        input logic [7:0] symbol0,
        input logic       bit42,
        input logic       bit43,
        input logic [7:0] expLink,
        input logic [7:0] expLane
    );
        logic m;
        m = 1'b0;
        case (st)
            4'd2: m = (linkField == PAD) && (laneField == PAD) &&
                      (((tsField == TS1) && (!bit43 || bit42)) || (tsField == TS2));
            4'd3: m = (linkField == PAD) && (laneField == PAD) && (tsField == TS2);
            4'd4: begin
                if (DEVICETYPE == 0)
                    m = (linkField == expLink) && (laneField == PAD) && (tsField == TS1);
                else
                    m = (linkField != PAD) && (laneField == PAD) && (tsField == TS1);
            end
            4'd5: m = (linkField == expLink) && (laneField != PAD) && (tsField == TS1);
            4'd6, 4'd7: begin
                if (DEVICETYPE == 0)
                    m = (linkField == expLink) && (laneField == expLane) && (tsField == TS1);
                else
                    m = (linkField == expLink) && (laneField == expLane) && (tsField == TS2);
            end
            4'd8: m = (linkField == expLink) && (laneField == expLane) && (tsField == TS2);
            4'd9: m = (symbol0 == 8'h00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    logic [3:0] prevSubstate_q;
    logic       substateChange;

    assign substateChange = (substate != prevSubstate_q);

    // Remember last cycle's substate so a transition can clear every lane.
    always_ff @(posedge clk) begin
        if (reset)
            prevSubstate_q <= 4'd0;
        else
            prevSubstate_q <= substate;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [127:0]     set;
        logic [7:0]       linkField;
        logic [7:0]       laneField;
        logic [7:0]       tsField;
        logic [7:0]       symbol0;
        logic [7:0]       rateField;
        logic             bit42;
        logic             bit43;
        logic             matchHit;
        logic             unusedBits;
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] count_d;
        logic [7:0]       rate_q;
        logic [7:0]       rate_d;
        logic             upcfg_q;
        logic             upcfg_d;

        assign set        = orderedset[i*128 +: 128];
        assign symbol0    = set[7:0];
        assign linkField  = set[15:8];
        assign laneField  = set[23:16];
        assign rateField  = set[39:32];
        assign bit42      = set[42];
        assign bit43      = set[43];
        assign tsField    = set[87:80];
        assign unusedBits = ^{set[127:88], set[79:44], set[41:40], set[31:24]};

        assign matchHit = setMatches(substate, linkField, laneField, tsField, symbol0,
                                     bit42, bit43, linkNumber, laneNumber[i*8 +: 8]);

        // Next lane state: clear on substate change, otherwise count/capture on valid sets.
        always_comb begin
            count_d = count_q;
            rate_d  = rate_q;
            upcfg_d = upcfg_q;
            if (substateChange) begin
                count_d = '0;
                rate_d  = 8'd0;
                upcfg_d = 1'b0;
            end else if (valid[i]) begin
                if (matchHit) begin
                    if ((count_q == '0) ||
                        ((substate == 4'd8) && ((rateField != rate_q) || (bit42 != upcfg_q)))) begin
                        count_d = CNT_ONE;
                        rate_d  = rateField;
                        upcfg_d = bit42;
                    end else if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_ONE;
                    end
                end else begin
                    count_d = '0;
                end
            end
        end

        // Lane state registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                count_q <= '0;
                rate_q  <= 8'd0;
                upcfg_q <= 1'b0;
            end else begin
                count_q <= count_d;
                rate_q  <= rate_d;
                upcfg_q <= upcfg_d;
            end
        end

        assign lane_count[i*CNT_W +: CNT_W] = count_q;
        assign rateid[i*8 +: 8]             = rate_q;
        assign upconfigure_capability[i]    = upcfg_q;
        assign lane_done[i] = (required_count != '0) && (count_q >= required_count);
    end

    assign all_done = (lane_mask != '0) && ((lane_done & lane_mask) == lane_mask);

endmodule

// File: tb/tb_os_lane_checker.sv
// tb_os_lane_checker
// Directed test of os_lane_checker with LANES=4, DEVICETYPE=0, CNT_W=4.
module tb_os_lane_checker;

   localparam logic [7:0] PAD = 8'hF7;
   localparam logic [7:0] TS1 = 8'h2A;
   localparam logic [7:0] TS2 = 8'h45;

   logic         clk;
   logic         reset;
   logic [3:0]   substate;
   logic [7:0]   linkNumber;
   logic [31:0]  laneNumber;
   logic [511:0] orderedset;
   logic [3:0]   valid;
   logic [3:0]   lane_mask;
   logic [3:0]   required_count;
   logic [15:0]  lane_count;
   logic [3:0]   lane_done;
   logic         all_done;
   logic [31:0]  rateid;
   logic [3:0]   upconfigure_capability;

   int errors = 0;
   int checks = 0;

   os_lane_checker #(.LANES(4), .DEVICETYPE(0), .CNT_W(4)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .substate               (substate),
      .linkNumber             (linkNumber),
      .laneNumber             (laneNumber),
      .orderedset             (orderedset),
      .valid                  (valid),
      .lane_mask              (lane_mask),
      .required_count         (required_count),
      .lane_count             (lane_count),
      .lane_done              (lane_done),
      .all_done               (all_done),
      .rateid                 (rateid),
      .upconfigure_capability (upconfigure_capability)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Builds one lane's 128-bit ordered set from its fields.
   function automatic logic [127:0] mkSet(input logic [7:0] link, input logic [7:0] lane,
                                          input logic [7:0] ts, input logic [7:0] rate,
                                          input logic b42, input logic b43, input logic [7:0] sym0);
      logic [127:0] s;
      s = '0;
      s[7:0]   = sym0;
      s[15:8]  = link;
      s[23:16] = lane;
      s[39:32] = rate;
      s[42]    = b42;
      s[43]    = b43;
      s[87:80] = ts;
      return s;
   endfunction

   // Same count replicated across all four lanes.
   function automatic logic [15:0] rep4(input int c);
      logic [3:0] n;
      n = 4'(c);
      return {n, n, n, n};
   endfunction

   // Advances one clock edge and settles just after it.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Compares one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Directed sequence covering reset, each test-plan scenario and the boundaries.
   initial begin
      logic [127:0] g;
      reset          = 1'b1;
      substate       = 4'd0;
      linkNumber     = 8'h00;
      laneNumber     = 32'h0;
      orderedset     = '0;
      valid          = 4'h0;
      lane_mask      = 4'hF;
      required_count = 4'd0;
      applyStimulus();
      applyStimulus();
      checkOutput("reset_count", 64'(lane_count), 64'h0);
      checkOutput("reset_done", 64'(lane_done), 64'h0);
      checkOutput("reset_all", 64'(all_done), 64'h0);
      checkOutput("reset_rateid", 64'(rateid), 64'h0);
      reset = 1'b0;

      // Substate 3: TS2 PAD/PAD on all lanes, counts 1..8.
      substate       = 4'd3;
      required_count = 4'd8;
      applyStimulus();
      g          = mkSet(PAD, PAD, TS2, 8'h00, 1'b0, 1'b0, 8'hBC);
      orderedset = {g, g, g, g};
      valid      = 4'hF;
      for (int n = 1; n <= 8; n++) begin
         applyStimulus();
         checkOutput($sformatf("s3_count%0d", n), 64'(lane_count), 64'(rep4(n)));
         if (n == 7) checkOutput("s3_done7", 64'(lane_done), 64'h0);
         if (n == 8) begin
            checkOutput("s3_done8", 64'(lane_done), 64'hF);
            checkOutput("s3_all8", 64'(all_done), 64'h1);
         end
      end

      // Substate 4: lane 2 gets a wrong link number after three good sets.
      valid          = 4'h0;
      substate       = 4'd4;
      linkNumber     = 8'h05;
      required_count = 4'd4;
      applyStimulus();
      checkOutput("s4_cleared", 64'(lane_count), 64'h0);
      g          = mkSet(8'h05, PAD, TS1, 8'h00, 1'b0, 1'b0, 8'hBC);
      orderedset = {g, g, g, g};
      valid      = 4'hF;
      for (int n = 0; n < 3; n++) applyStimulus();
      checkOutput("s4_count3", 64'(lane_count), 64'h3333);
      orderedset = {g, mkSet(8'h06, PAD, TS1, 8'h00, 1'b0, 1'b0, 8'hBC), g, g};
      applyStimulus();
      checkOutput("s4_lane2_drop", 64'(lane_count), 64'h4044);
      checkOutput("s4_done", 64'(lane_done), 64'hB);
      checkOutput("s4_all_maskF", 64'(all_done), 64'h0);
      lane_mask = 4'hB;
      #1;
      checkOutput("s4_all_maskB", 64'(all_done), 64'h1);
      lane_mask = 4'hF;

      // Substate 8: rate identifier change restarts the run on lane 0.
      valid      = 4'h0;
      substate   = 4'd8;
      laneNumber = 32'h03020100;
      applyStimulus();
      orderedset = {384'h0, mkSet(8'h05, 8'h00, TS2, 8'h02, 1'b0, 1'b0, 8'hBC)};
      valid      = 4'h1;
      for (int n = 0; n < 3; n++) applyStimulus();
      checkOutput("s8_count3", 64'(lane_count), 64'h0003);
      checkOutput("s8_rate02", 64'(rateid), 64'h00000002);
      orderedset = {384'h0, mkSet(8'h05, 8'h00, TS2, 8'h06, 1'b0, 1'b0, 8'hBC)};
      applyStimulus();
      checkOutput("s8_restart", 64'(lane_count), 64'h0001);
      checkOutput("s8_rate06", 64'(rateid), 64'h00000006);

      // Substate 2: TS1 qualified by bits 43/42, TS2 accepted.
      valid    = 4'h0;
      substate = 4'd2;
      applyStimulus();
      orderedset = {mkSet(PAD, PAD, TS2, 8'h00, 1'b0, 1'b0, 8'hBC),
                    mkSet(PAD, PAD, TS1, 8'h00, 1'b1, 1'b1, 8'hBC),
                    mkSet(PAD, PAD, TS1, 8'h00, 1'b0, 1'b1, 8'hBC),
                    mkSet(PAD, PAD, TS1, 8'h00, 1'b0, 1'b0, 8'hBC)};
      valid = 4'hF;
      applyStimulus();
      checkOutput("s2_count", 64'(lane_count), 64'h1101);
      checkOutput("s2_upcfg", 64'(upconfigure_capability), 64'h4);

      // Substate 9: 20 matches saturate at 15.
      valid          = 4'h0;
      substate       = 4'd9;
      required_count = 4'd15;
      applyStimulus();
      orderedset = '0;
      valid      = 4'hF;
      for (int n = 1; n <= 20; n++) begin
         applyStimulus();
         checkOutput($sformatf("s9_count%0d", n), 64'(lane_count), 64'(rep4(n > 15 ? 15 : n)));
         if (n >= 15) checkOutput($sformatf("s9_done%0d", n), 64'(lane_done), 64'hF);
      end

      // Substates 6 -> 7 with matching sets arriving across the change.
      valid          = 4'h0;
      substate       = 4'd6;
      required_count = 4'd8;
      applyStimulus();
      orderedset = {mkSet(8'h05, 8'h03, TS1, 8'h11, 1'b1, 1'b0, 8'hBC),
                    mkSet(8'h05, 8'h02, TS1, 8'h11, 1'b1, 1'b0, 8'hBC),
                    mkSet(8'h05, 8'h01, TS1, 8'h11, 1'b1, 1'b0, 8'hBC),
                    mkSet(8'h05, 8'h00, TS1, 8'h11, 1'b1, 1'b0, 8'hBC)};
      valid = 4'hF;
      for (int n = 0; n < 5; n++) applyStimulus();
      checkOutput("s6_count5", 64'(lane_count), 64'h5555);
      checkOutput("s6_rate", 64'(rateid), 64'h11111111);
      checkOutput("s6_upcfg", 64'(upconfigure_capability), 64'hF);
      substate = 4'd7;
      applyStimulus();
      checkOutput("s7_clear", 64'(lane_count), 64'h0);
      checkOutput("s7_clear_rate", 64'(rateid), 64'h0);
      applyStimulus();
      checkOutput("s7_count1", 64'(lane_count), 64'h1111);
      for (int n = 0; n < 5; n++) applyStimulus();
      checkOutput("s7_count6", 64'(lane_count), 64'h6666);

      // Mid-run reset, then required_count of zero disables done outputs.
      reset = 1'b1;
      applyStimulus();
      checkOutput("mid_reset_count", 64'(lane_count), 64'h0);
      checkOutput("mid_reset_done", 64'(lane_done), 64'h0);
      checkOutput("mid_reset_all", 64'(all_done), 64'h0);
      checkOutput("mid_reset_rate", 64'(rateid), 64'h0);
      checkOutput("mid_reset_upcfg", 64'(upconfigure_capability), 64'h0);
      reset          = 1'b0;
      required_count = 4'd0;
      applyStimulus();
      checkOutput("post_reset_clear", 64'(lane_count), 64'h0);
      for (int n = 0; n < 3; n++) applyStimulus();
      checkOutput("req0_count", 64'(lane_count), 64'h3333);
      checkOutput("req0_done", 64'(lane_done), 64'h0);
      checkOutput("req0_all", 64'(all_done), 64'h0);
      required_count = 4'd2;
      #1;
      checkOutput("req2_done", 64'(lane_done), 64'hF);
      checkOutput("req2_all", 64'(all_done), 64'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
